entity_rasterizer: RTL and testbench
====================================

// Module: entity_rasterizer
// PURPOSE
//  Reader end of the entity list: consumes the entity RAM that entities_drawer fills
//  (21-bit words {type[2:0], y[8:0], x[8:0]}, count in entities_number).
//  On start, walks entries 0..count-1 in order and paints each as a SIZE x SIZE square into
//  the frame buffer, one pixel per clock. Later entries overwrite earlier ones, so background
//  (0..99) lies under movers (100+). Sits between entity RAM and the VGA-side frame buffer.
// PARAMETERS
//  SIZE      48   square edge in pixels (power of two not required)
//  FB_W      480  frame buffer width in pixels; x >= FB_W is clipped
//  FB_H      480  frame buffer height in pixels; y >= FB_H is clipped
//  FB_AW     18   frame buffer address width (FB_W*FB_H <= 2**FB_AW)
//  SKIP_TYPE 7    entity type that is never drawn (transparent)
// PORTS
//  clk              in   1      system clock, all logic on rising edge
//  rst_n            in   1      asynchronous active-low reset
//  start            in   1      1-cycle pulse: rasterize current list (ignored unless IDLE)
//  entities_number  in   8      entries to draw; sampled on the accepted start
//  address_read_ent out  8      entity RAM read address (registered)
//  data_read_ent    in   21     entity RAM read data, valid 1 cycle after address
//  fb_addr          out  FB_AW  frame buffer write address = py*FB_W + px (registered)
//  fb_data          out  4      {edge, type[2:0]} (registered)
//  fb_wren          out  1      frame buffer write strobe (registered)
//  busy             out  1      high whenever state != IDLE
//  done             out  1      1-cycle pulse when list finished
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; address_read_ent=0, fb_addr=0, fb_data=0, fb_wren=0,
//   busy=0, done=0; idx, dx, dy, latched count/entity cleared. Reset mid-frame aborts with no
//   further writes; list is NOT resumed.
//  FSM: IDLE -> FETCH -> WAIT -> DRAW -> (FETCH | DONE) -> IDLE.
//   IDLE : start=1 -> latch count=entities_number, idx=0; count==0 -> DONE else FETCH.
//   FETCH: address_read_ent=idx presented this cycle (1 cycle).
//   WAIT : data_read_ent valid; captured at end of cycle into type/y/x regs; dx=dy=0.
//   DRAW : SIZE*SIZE cycles, dx fastest (0..SIZE-1), then dy. After (SIZE-1,SIZE-1):
//          idx==count-1 -> DONE, else idx+1 -> FETCH.
//   DONE : done=1 for exactly this cycle, then IDLE.
//  Per-entity cost exactly 2+SIZE*SIZE cycles (2306 at default); start->done = 1 + count*2306
//   + 1 cycles for count>0, 2 cycles for count==0 (start edge to done-high cycle inclusive).
//  Pixel write: for DRAW cycle at (dx,dy): px=x+dx, py=y+dy computed 10 bits wide (no wrap);
//   write iff px<FB_W, py<FB_H, type!=SKIP_TYPE. Strobe/addr/data appear the NEXT cycle
//   (1-cycle registered output); fb_wren=0 on all other cycles, incl. the write-free
//   FETCH/WAIT/DONE.
//  Clipped or skipped entities still consume full 2+SIZE*SIZE cycles (fixed frame timing).
//  Off-board 9-bit positions (e.g. negative shifts wrapped to 496..511) clip naturally.
//  start while busy: ignored, no restart, no effect on count. start with done same cycle:
//   ignored (state is DONE, not IDLE).
//  entities_number changes during a run: no effect (latched value used).
//  fb_addr arithmetic: py*FB_W + px in FB_AW bits; only formed for in-range pixels.
// CONFIGURATION
//  ENTITY_BORDER_EN defined: fb_data[3]=1 when dx==0|dx==SIZE-1|dy==0|dy==SIZE-1 (outline
//   bit for VGA side to darken), else 0.
//  ENTITY_BORDER_EN undefined: fb_data[3] tied 0; no edge logic; timing identical.
// TESTING
//  1 count=0, start -> busy 1 cycle, done pulse 2nd cycle after start edge, zero fb_wren.
//  2 count=1, entry0={3'b011,y=48,x=96} -> 2304 writes; first addr 23136 data 4'b0011 (no
//    border) / 4'b1011 (border); last addr 45743; done at cycle 2308 after start.
//  3 count=1, x=460,y=0 type 1 -> 960 writes (px 460..479 each row), none with px>=480;
//    y=496 -> 0 writes, done still at cycle 2308.
//  4 count=2, entry0 type0 at (0,0), entry1 type2 at (24,24): model FB shows type2 over
//    overlap 24..47; entry1 type 7 instead -> overlap stays type0.
//  5 start pulsed again at cycle 100 of a run and entities_number changed -> ignored; single
//    done at expected cycle. rst_n low at cycle 500 -> fb_wren 0 immediately, busy 0, no done.
//  6 count=101 (full drawer list) -> exactly 101*2306+2 cycles, scoreboard vs reference model.

Source files
------------

// File: rtl/entity_rasterizer_if.sv
// entity_rasterizer_if: entity-RAM read port, frame-buffer write port and run control of the rasterizer.
interface entity_rasterizer_if #(
    parameter int FB_AW = 18
);
    logic             start;
    logic [7:0]       entities_number;
    logic [7:0]       address_read_ent;
    logic [20:0]      data_read_ent;
    logic [FB_AW-1:0] fb_addr;
    logic [3:0]       fb_data;
    logic             fb_wren;
    logic             busy;
    logic             done;
    modport master (
        input  start, entities_number, data_read_ent,
        output address_read_ent, fb_addr, fb_data, fb_wren, busy, done
    );
    modport slave (
        output start, entities_number, data_read_ent,
        input  address_read_ent, fb_addr, fb_data, fb_wren, busy, done
    );
endinterface

// File: rtl/entity_rasterizer.sv
// entity_rasterizer: paints entity-RAM entries 0..count-1 as SIZE x SIZE squares, one pixel per clock.
// Define ENTITY_BORDER_EN to set fb_data[3] on the outline pixels of each square.
module entity_rasterizer #(
    parameter int SIZE      = 48,
    parameter int FB_W      = 480,
    parameter int FB_H      = 480,
    parameter int FB_AW     = 18,
    parameter int SKIP_TYPE = 7
) (
    input logic clk,
    input logic rst_n,
    entity_rasterizer_if.master bus
);
    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0]    LAST  = CW'(SIZE - 1);
    localparam logic [9:0]       W10   = 10'(FB_W);
    localparam logic [9:0]       H10   = 10'(FB_H);
    localparam logic [2:0]       SKIP  = 3'(SKIP_TYPE);
    localparam logic [FB_AW-1:0] FBW_A = FB_AW'(FB_W);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       count_q, count_d, idx_q, idx_d, addr_q, addr_d;
    logic [20:0]      ent_q, ent_d;
    logic [CW-1:0]    dx_q, dx_d, dy_q, dy_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic [3:0]       fb_data_q, fb_data_d;
    logic             fb_wren_q, fb_wren_d, done_q, done_d;
    logic [9:0]       px, py;
    logic             hit, brd, last_x, last_y;

    // 10-bit sums so that positions near 511 clip instead of wrapping onto the board
    assign px     = 10'(ent_q[8:0]) + 10'(dx_q);
    assign py     = 10'(ent_q[17:9]) + 10'(dy_q);
    assign last_x = dx_q == LAST;
    assign last_y = dy_q == LAST;
    assign hit    = (state_q == DRAW) && (px < W10) && (py < H10) && (ent_q[20:18] != SKIP);
`ifdef ENTITY_BORDER_EN
    assign brd = (dx_q == '0) || last_x || (dy_q == '0) || last_y;
`else
    assign brd = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        ent_d     = ent_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        fb_wren_d = hit;
        fb_addr_d = hit ? FB_AW'(py) * FBW_A + FB_AW'(px) : fb_addr_q;
        fb_data_d = hit ? {brd, ent_q[20:18]} : fb_data_q;
        case (state_q)
            IDLE: if (bus.start) begin
                count_d = bus.entities_number;
                idx_d   = '0;
                addr_d  = '0;
                state_d = (bus.entities_number == 8'd0) ? DONE : FETCH;
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                ent_d   = bus.data_read_ent;
                dx_d    = '0;
                dy_d    = '0;
                state_d = DRAW;
            end
            DRAW: begin
                dx_d = last_x ? '0 : dx_q + 1'b1;
                dy_d = last_x ? dy_q + 1'b1 : dy_q;
                if (last_x && last_y) begin
                    state_d = (idx_q == count_q - 8'd1) ? DONE : FETCH;
                    idx_d   = idx_q + 8'd1;
                    addr_d  = idx_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            ent_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            fb_wren_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            ent_q     <= ent_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            fb_wren_q <= fb_wren_d;
            done_q    <= done_d;
        end
    end

    assign bus.address_read_ent = addr_q;
    assign bus.fb_addr          = fb_addr_q;
    assign bus.fb_data          = fb_data_q;
    assign bus.fb_wren          = fb_wren_q;
    assign bus.busy             = state_q != IDLE;
    assign bus.done             = done_q;
endmodule

// File: tb/tb_entity_rasterizer.sv
// tb_entity_rasterizer: randomized and directed runs; expected pixel writes are queued by a reference
// model and popped by a monitor whenever a DUT strobes fb_wren.
module tb_entity_rasterizer;
    localparam int S0 = 48, W0 = 480, H0 = 480;
    localparam int S1 = 5,  W1 = 64,  H1 = 40, A1 = 12;

    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    entity_rasterizer_if #(.FB_AW(18)) b0 ();
    entity_rasterizer_if #(.FB_AW(A1)) b1 ();
    entity_rasterizer u_dut (.clk(clk), .rst_n(rst_n), .bus(b0));
    // small instance keeps the full 101-entry list well inside the cycle budget
    entity_rasterizer #(.SIZE(S1), .FB_W(W1), .FB_H(H1), .FB_AW(A1)) u_small (.clk(clk), .rst_n(rst_n), .bus(b1));

    logic [20:0] ram0 [256];
    logic [20:0] ram1 [256];
    logic [3:0]  dfb  [1<<18];
    logic [21:0] q0 [$];
    logic [21:0] q1 [$];
    logic [21:0] e0, e1;
    logic [17:0] fa0, la0;
    logic [3:0]  fd0;
    int cmp = 0, bad = 0, wr0 = 0, wr1 = 0;

    always @(posedge clk) begin
        b0.data_read_ent <= ram0[b0.address_read_ent];
        b1.data_read_ent <= ram1[b1.address_read_ent];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (b0.fb_wren) begin
            if (wr0 == 0) begin fa0 = b0.fb_addr; fd0 = b0.fb_data; end
            la0 = b0.fb_addr;
            wr0++;
            dfb[b0.fb_addr] = b0.fb_data;
            if (q0.size() == 0) begin
                cmp++; bad++;
                $display("FAIL wr0_unexpected: got write addr %0d, want none", b0.fb_addr);
            end else begin
                e0 = q0.pop_front();
                chk("wr0_addr", 32'(b0.fb_addr), 32'(e0[21:4]));
                chk("wr0_data", 32'(b0.fb_data), 32'(e0[3:0]));
            end
        end
        if (b1.fb_wren) begin
            wr1++;
            if (q1.size() == 0) begin
                cmp++; bad++;
                $display("FAIL wr1_unexpected: got write addr %0d, want none", b1.fb_addr);
            end else begin
                e1 = q1.pop_front();
                chk("wr1_addr", 32'(b1.fb_addr), 32'(e1[21:4]));
                chk("wr1_data", 32'(b1.fb_data), 32'(e1[3:0]));
            end
        end
    end

    // every square pixel inside the board, in list order, later entries landing later
    task automatic model(input int sel, input int n);
        int sz, fw, fh, px, py, a;
        logic [20:0] w;
        logic [3:0] d;
        sz = sel != 0 ? S1 : S0;
        fw = sel != 0 ? W1 : W0;
        fh = sel != 0 ? H1 : H0;
        for (int e = 0; e < n; e++) begin
            w = sel != 0 ? ram1[e] : ram0[e];
            for (int dy = 0; dy < sz; dy++)
                for (int dx = 0; dx < sz; dx++) begin
                    px = int'(w[8:0]) + dx;
                    py = int'(w[17:9]) + dy;
                    if (px < fw && py < fh && w[20:18] != 3'd7) begin
`ifdef ENTITY_BORDER_EN
                        d = {(dx == 0 || dx == sz - 1 || dy == 0 || dy == sz - 1), w[20:18]};
`else
                        d = {1'b0, w[20:18]};
`endif
                        a = py * fw + px;
                        if (sel != 0) q1.push_back({18'(a), d});
                        else q0.push_back({18'(a), d});
                    end
                end
        end
    endtask

    // mode 1: restart attempt mid-run and at the done cycle; mode 2: reset at cycle 500
    task automatic run(input int sel, input int n, input int mode, output int c);
        int lim;
        lim = 2 + n * (sel != 0 ? 2 + S1 * S1 : 2 + S0 * S0) + 10;
        wr0 = 0;
        wr1 = 0;
        model(sel, n);
        @(negedge clk);
        if (sel != 0) begin b1.entities_number = 8'(n); b1.start = 1'b1; end
        else begin b0.entities_number = 8'(n); b0.start = 1'b1; end
        @(posedge clk); #1;
        b0.start = 1'b0;
        b1.start = 1'b0;
        c = 2;
        chk("busy_after_start", 32'(sel != 0 ? b1.busy : b0.busy), 32'd1);
        while (!(sel != 0 ? b1.done : b0.done) && c < lim) begin
            @(posedge clk); #1;
            c++;
            if (mode == 1) begin
                b0.start = c == 100;
                if (c == 100) b0.entities_number = 8'd5;
            end
            if (mode == 2 && c == 500) begin
                rst_n = 1'b0;
                break;
            end
        end
        if (mode == 1) b0.start = 1'b1;
    endtask

    task automatic check(input int sel, input int n, input int c, input string tag);
        chk({tag, "_done_cycle"}, 32'(c), 32'(2 + n * (sel != 0 ? 2 + S1 * S1 : 2 + S0 * S0)));
        @(posedge clk); #1;
        b0.start = 1'b0;
        b1.start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(sel != 0 ? b1.done : b0.done), 32'd0);
        chk({tag, "_busy_idle"}, 32'(sel != 0 ? b1.busy : b0.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_pending"}, 32'(sel != 0 ? q1.size() : q0.size()), 32'd0);
    endtask

    initial begin
        int c, n, w;
        b0.start = 1'b0; b1.start = 1'b0;
        b0.entities_number = 8'd0; b1.entities_number = 8'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(b0.busy), 0);
        chk("rst_done", 32'(b0.done), 0);
        chk("rst_wren", 32'(b0.fb_wren), 0);
        chk("rst_fb_addr", 32'(b0.fb_addr), 0);
        chk("rst_fb_data", 32'(b0.fb_data), 0);
        chk("rst_ram_addr", 32'(b0.address_read_ent), 0);
        chk("rst_small_busy", 32'(b1.busy), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        run(0, 0, 0, c); check(0, 0, c, "t1");
        chk("t1_writes", 32'(wr0), 0);

        ram0[0] = {3'b011, 9'd48, 9'd96};
        run(0, 1, 0, c); check(0, 1, c, "t2");
        chk("t2_writes", 32'(wr0), 2304);
        chk("t2_first_addr", 32'(fa0), 23136);
`ifdef ENTITY_BORDER_EN
        chk("t2_first_data", 32'(fd0), 32'b1011);
`else
        chk("t2_first_data", 32'(fd0), 32'b0011);
`endif
        chk("t2_last_addr", 32'(la0), 45743);

        ram0[0] = {3'd1, 9'd0, 9'd460};
        run(0, 1, 0, c); check(0, 1, c, "t3a");
        chk("t3a_writes", 32'(wr0), 960);
        ram0[0] = {3'd1, 9'd496, 9'd460};
        run(0, 1, 0, c); check(0, 1, c, "t3b");
        chk("t3b_writes", 32'(wr0), 0);

        for (int y = 0; y < 80; y++) for (int x = 0; x < 80; x++) dfb[y * 480 + x] = 4'hF;
        ram0[0] = 21'd0;
        ram0[1] = {3'd2, 9'd24, 9'd24};
        run(0, 2, 0, c); check(0, 2, c, "t4a");
        chk("t4a_overlap", 32'(dfb[30 * 480 + 30][2:0]), 2);
        chk("t4a_corner", 32'(dfb[47 * 480 + 47][2:0]), 2);
        chk("t4a_under", 32'(dfb[10 * 480 + 10][2:0]), 0);
        chk("t4a_mover", 32'(dfb[60 * 480 + 60][2:0]), 2);
        for (int y = 0; y < 80; y++) for (int x = 0; x < 80; x++) dfb[y * 480 + x] = 4'hF;
        ram0[1] = {3'd7, 9'd24, 9'd24};
        run(0, 2, 0, c); check(0, 2, c, "t4b");
        chk("t4b_overlap", 32'(dfb[30 * 480 + 30][2:0]), 0);
        chk("t4b_clear", 32'(dfb[60 * 480 + 60]), 32'hF);

        ram0[0] = {3'd4, 9'd100, 9'd200};
        run(0, 1, 1, c); check(0, 1, c, "t5");
        chk("t5_writes", 32'(wr0), 2304);
        run(0, 1, 2, c);
        #1;
        chk("t5_abort_wren", 32'(b0.fb_wren), 0);
        chk("t5_abort_busy", 32'(b0.busy), 0);
        chk("t5_abort_done", 32'(b0.done), 0);
        w = wr0;
        q0.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_resume", 32'(b0.busy), 0);
        chk("t5_no_writes", 32'(wr0), 32'(w));

        for (int k = 0; k < 4; k++) begin
            n = (k == 0) ? 101 : int'($urandom_range(1, 30));
            for (int e = 0; e < n; e++)
                ram1[e] = {3'($urandom_range(0, 7)),
                           9'(($urandom_range(0, 3) == 0) ? $urandom_range(496, 511) : $urandom_range(0, 45)),
                           9'(($urandom_range(0, 3) == 0) ? $urandom_range(496, 511) : $urandom_range(0, 70))};
            run(1, n, 0, c); check(1, n, c, "t6");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
